// File: rtl/cm_pkg.sv
// cm_pkg: shared types for the cm_* blocks
package cm_pkg;
    typedef enum logic {SORT_MAX, SORT_MIN} t_sort_dir;
endpackage

// File: rtl/cm_arb_sched.sv
// cm_arb_sched: priority arbiter with round-robin tie-break and a packet-locked grant
module cm_arb_sched #(
    parameter int N_REQ = 4,
    parameter int PRIO_W = 3,
    parameter cm_pkg::t_sort_dir SORT_DIR = cm_pkg::SORT_MAX,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_vld,
    input  logic [N_REQ-1:0]        i_req_last,
    input  logic [N_REQ*PRIO_W-1:0] i_req_prio,
    output logic [N_REQ-1:0]        o_req_rdy,
    output logic                    o_vld,
    output logic                    o_last,
    input  logic                    i_rdy,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [IDX_W-1:0]        o_gnt_idx,
    output logic                    o_busy
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, rr_ptr_q, rr_ptr_d, win;
    logic [PRIO_W-1:0] prio [N_REQ];
    logic [PRIO_W-1:0] best;
    logic found, lock, hs_last;
    int j;
    always_comb begin
        for (int k = 0; k < N_REQ; k++) prio[k] = i_req_prio[k*PRIO_W +: PRIO_W];
    end
    // Best priority first, then the first equal-best requester at or after rr_ptr.
    always_comb begin
        best = SORT_DIR == cm_pkg::SORT_MAX ? '0 : '1;
        for (int k = 0; k < N_REQ; k++)
            best = i_req_vld[k] && (SORT_DIR == cm_pkg::SORT_MAX ? prio[k] > best : prio[k] < best) ? prio[k] : best;
        win = '0;
        found = 1'b0;
        j = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(rr_ptr_q) + i) % N_REQ;
            if (!found && i_req_vld[j] && prio[j] == best) begin
                found = 1'b1;
                win = IDX_W'(j);
            end
        end
    end
    assign o_busy    = state_q == LOCK;
    assign lock      = o_busy & ~i_rst;
    assign o_vld     = lock & i_req_vld[idx_q];
    assign o_last    = lock & i_req_last[idx_q];
    assign o_req_rdy = lock ? N_REQ'(i_rdy) << idx_q : '0;
    assign o_gnt     = gnt_q;
    assign o_gnt_idx = idx_q;
    assign hs_last   = o_vld & i_rdy & o_last;
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && |i_req_vld) begin
            state_d = LOCK;
            idx_d   = win;
            gnt_d   = N_REQ'(1) << win;
        end else if (hs_last) begin
            state_d  = IDLE;
            gnt_d    = '0;
            rr_ptr_d = idx_q == IDX_W'(N_REQ - 1) ? '0 : idx_q + 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_cm_arb_sched.sv
// tb_cm_arb_sched: directed checks of arbitration, tie-break, locking and reset
module tb_cm_arb_sched;
    logic i_clk = 1'b0;
    logic i_rst, i_rdy;
    logic [3:0] vld, last;
    logic [2:0] pr [4];
    logic [11:0] prio_bus;
    logic [3:0] o_req_rdy, o_gnt, m_req_rdy, m_gnt;
    logic [1:0] o_gnt_idx, m_gnt_idx;
    logic o_vld, o_last, o_busy, m_vld, m_last, m_busy;
    int n_chk = 0;
    int n_fail = 0;
    int hs;
    assign prio_bus = {pr[3], pr[2], pr[1], pr[0]};
    always #5 i_clk = ~i_clk;
    cm_arb_sched #(.N_REQ(4), .PRIO_W(3), .SORT_DIR(cm_pkg::SORT_MAX)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_vld(vld), .i_req_last(last), .i_req_prio(prio_bus),
        .o_req_rdy(o_req_rdy), .o_vld(o_vld), .o_last(o_last), .i_rdy(i_rdy),
        .o_gnt(o_gnt), .o_gnt_idx(o_gnt_idx), .o_busy(o_busy));
    cm_arb_sched #(.N_REQ(4), .PRIO_W(3), .SORT_DIR(cm_pkg::SORT_MIN)) dut_min (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_vld(vld), .i_req_last(last), .i_req_prio(prio_bus),
        .o_req_rdy(m_req_rdy), .o_vld(m_vld), .o_last(m_last), .i_rdy(i_rdy),
        .o_gnt(m_gnt), .o_gnt_idx(m_gnt_idx), .o_busy(m_busy));
    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask
    task automatic test_reset;
        i_rst = 1'b1; vld = '0; last = '0; i_rdy = 1'b0;
        for (int k = 0; k < 4; k++) pr[k] = '0;
        tick; tick;
        vld = 4'hF; i_rdy = 1'b1; #1;
        n_chk++; if (o_gnt !== 4'b0000) begin $display("FAIL reset_gnt: got %b expected 0000", o_gnt); n_fail++; end
        n_chk++; if (o_gnt_idx !== 2'd0) begin $display("FAIL reset_idx: got %0d expected 0", o_gnt_idx); n_fail++; end
        n_chk++; if (o_busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", o_busy); n_fail++; end
        n_chk++; if (o_vld !== 1'b0) begin $display("FAIL reset_vld: got %b expected 0", o_vld); n_fail++; end
        n_chk++; if (o_req_rdy !== 4'b0000) begin $display("FAIL reset_rdy: got %b expected 0000", o_req_rdy); n_fail++; end
        n_chk++; if (dut.rr_ptr_q !== 2'd0) begin $display("FAIL reset_rr: got %0d expected 0", dut.rr_ptr_q); n_fail++; end
        vld = '0; i_rdy = 1'b0; i_rst = 1'b0;
        tick;
    endtask
    task automatic test_single;
        vld = 4'b0001; last = 4'b0001; pr[0] = 3'd2; i_rdy = 1'b1;
        #1;
        n_chk++; if (o_gnt !== 4'b0000) begin $display("FAIL single_latency: got %b expected 0000", o_gnt); n_fail++; end
        tick;
        n_chk++; if (o_gnt !== 4'b0001) begin $display("FAIL single_gnt: got %b expected 0001", o_gnt); n_fail++; end
        n_chk++; if (o_busy !== 1'b1) begin $display("FAIL single_busy: got %b expected 1", o_busy); n_fail++; end
        n_chk++; if ({o_vld, o_last} !== 2'b11) begin $display("FAIL single_vld_last: got %b expected 11", {o_vld, o_last}); n_fail++; end
        n_chk++; if (o_req_rdy !== 4'b0001) begin $display("FAIL single_rdy: got %b expected 0001", o_req_rdy); n_fail++; end
        tick;
        vld = '0; last = '0; #1;
        n_chk++; if (o_gnt !== 4'b0000) begin $display("FAIL single_release: got %b expected 0000", o_gnt); n_fail++; end
        n_chk++; if (o_busy !== 1'b0) begin $display("FAIL single_busy_clr: got %b expected 0", o_busy); n_fail++; end
        n_chk++; if (dut.rr_ptr_q !== 2'd1) begin $display("FAIL single_rr: got %0d expected 1", dut.rr_ptr_q); n_fail++; end
    endtask
    task automatic test_idle;
        tick; tick; tick;
        n_chk++; if (dut.rr_ptr_q !== 2'd1) begin $display("FAIL idle_rr: got %0d expected 1", dut.rr_ptr_q); n_fail++; end
        n_chk++; if (o_busy !== 1'b0) begin $display("FAIL idle_busy: got %b expected 0", o_busy); n_fail++; end
    endtask
    task automatic test_prio_dir;
        pr[1] = 3'd5; pr[3] = 3'd7; vld = 4'b1010; last = 4'b1010; i_rdy = 1'b1;
        tick;
        n_chk++; if (o_gnt !== 4'b1000) begin $display("FAIL max_gnt: got %b expected 1000", o_gnt); n_fail++; end
        n_chk++; if (o_gnt_idx !== 2'd3) begin $display("FAIL max_idx: got %0d expected 3", o_gnt_idx); n_fail++; end
        n_chk++; if (m_gnt !== 4'b0010) begin $display("FAIL min_gnt: got %b expected 0010", m_gnt); n_fail++; end
        n_chk++; if (m_gnt_idx !== 2'd1) begin $display("FAIL min_idx: got %0d expected 1", m_gnt_idx); n_fail++; end
        tick;
        vld = '0; last = '0; #1;
        n_chk++; if (dut.rr_ptr_q !== 2'd0) begin $display("FAIL max_rr_wrap: got %0d expected 0", dut.rr_ptr_q); n_fail++; end
    endtask
    task automatic test_round_robin;
        logic [3:0] exp [9];
        exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int k = 0; k < 4; k++) pr[k] = 3'd4;
        vld = 4'hF; last = 4'hF; i_rdy = 1'b1;
        tick;
        for (int i = 0; i < 9; i++) begin
            n_chk++; if (o_gnt !== exp[i]) begin $display("FAIL rr_step%0d: got %b expected %b", i, o_gnt, exp[i]); n_fail++; end
            tick;
        end
        vld = '0; last = '0; #1;
        n_chk++; if (dut.rr_ptr_q !== 2'd1) begin $display("FAIL rr_end_ptr: got %0d expected 1", dut.rr_ptr_q); n_fail++; end
    endtask
    task automatic test_back_to_back_lock;
        logic [6:0] rdy_seq, v_seq;
        rdy_seq = 7'b1101101;
        v_seq = 7'b1111011;
        hs = 0;
        pr[2] = 3'd3; vld = 4'b0100; last = '0; i_rdy = 1'b1;
        tick;
        vld[0] = 1'b1; pr[0] = 3'd7;
        for (int i = 0; i < 7; i++) begin
            vld[2] = v_seq[i]; i_rdy = rdy_seq[i]; last[2] = (i == 6); #1;
            n_chk++; if (o_gnt !== 4'b0100) begin $display("FAIL lock_gnt%0d: got %b expected 0100", i, o_gnt); n_fail++; end
            n_chk++; if (o_req_rdy !== (rdy_seq[i] ? 4'b0100 : 4'b0000)) begin $display("FAIL lock_rdy%0d: got %b expected %b", i, o_req_rdy, rdy_seq[i] ? 4'b0100 : 4'b0000); n_fail++; end
            n_chk++; if ({o_vld, o_last} !== {v_seq[i], i == 6}) begin $display("FAIL lock_vld_last%0d: got %b expected %b", i, {o_vld, o_last}, {v_seq[i], i == 6}); n_fail++; end
            hs += int'(o_vld & i_rdy);
            tick;
        end
        vld[2] = 1'b0; last[2] = 1'b0; last[0] = 1'b1; i_rdy = 1'b1; #1;
        n_chk++; if (hs !== 4) begin $display("FAIL lock_handshakes: got %0d expected 4", hs); n_fail++; end
        n_chk++; if (o_gnt !== 4'b0000) begin $display("FAIL lock_bubble: got %b expected 0000", o_gnt); n_fail++; end
        n_chk++; if (dut.rr_ptr_q !== 2'd3) begin $display("FAIL lock_rr: got %0d expected 3", dut.rr_ptr_q); n_fail++; end
        tick;
        n_chk++; if (o_gnt !== 4'b0001) begin $display("FAIL lock_next_gnt: got %b expected 0001", o_gnt); n_fail++; end
        tick;
        vld = '0; last = '0; #1;
    endtask
    task automatic test_reset_mid;
        pr[1] = 3'd1; vld = 4'b0010; last = '0; i_rdy = 1'b1;
        tick;
        n_chk++; if (o_gnt !== 4'b0010) begin $display("FAIL rstmid_gnt: got %b expected 0010", o_gnt); n_fail++; end
        i_rst = 1'b1; #1;
        n_chk++; if ({o_vld, o_req_rdy} !== 5'b0) begin $display("FAIL rstmid_comb: got %b expected 00000", {o_vld, o_req_rdy}); n_fail++; end
        tick;
        n_chk++; if (o_gnt !== 4'b0000) begin $display("FAIL rstmid_gnt_clr: got %b expected 0000", o_gnt); n_fail++; end
        n_chk++; if ({o_busy, o_vld, o_req_rdy} !== 6'b0) begin $display("FAIL rstmid_out: got %b expected 000000", {o_busy, o_vld, o_req_rdy}); n_fail++; end
        n_chk++; if (dut.rr_ptr_q !== 2'd0) begin $display("FAIL rstmid_rr: got %0d expected 0", dut.rr_ptr_q); n_fail++; end
        i_rst = 1'b0; vld = '0;
        tick;
    endtask
    task automatic test_prio_change;
        pr[0] = 3'd1; pr[1] = 3'd3; vld = 4'b0011; last = '0; i_rdy = 1'b1;
        tick;
        pr[0] = 3'd7;
        tick;
        n_chk++; if (o_gnt !== 4'b0010) begin $display("FAIL pchg_hold_gnt: got %b expected 0010", o_gnt); n_fail++; end
        n_chk++; if (o_gnt_idx !== 2'd1) begin $display("FAIL pchg_hold_idx: got %0d expected 1", o_gnt_idx); n_fail++; end
        last[1] = 1'b1;
        tick;
        n_chk++; if (o_gnt !== 4'b0000) begin $display("FAIL pchg_release: got %b expected 0000", o_gnt); n_fail++; end
        n_chk++; if (dut.rr_ptr_q !== 2'd2) begin $display("FAIL pchg_rr: got %0d expected 2", dut.rr_ptr_q); n_fail++; end
        tick;
        n_chk++; if (o_gnt !== 4'b0001) begin $display("FAIL pchg_new_gnt: got %b expected 0001", o_gnt); n_fail++; end
        vld = 4'b0001; last = 4'b0001;
        tick;
        vld = '0; last = '0;
        tick;
    endtask
    initial begin
        test_reset;
        test_single;
        test_idle;
        test_prio_dir;
        test_round_robin;
        test_back_to_back_lock;
        test_reset_mid;
        test_prio_change;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
